opl3_slot_scheduler: RTL and testbench
======================================

Name: opl3_slot_scheduler

Overview:
- Master sequencer for the OPL3 operator datapath.
- Divides `clk` into the sample-rate strobe. Once per sample it walks all 36 operator slots (2 banks × 18 operators), one slot every OP_CYCLES cycles.
- Drives the per-slot bank/operator indices that feed the downstream delay-line pipeline stages.
- Arbitrates the single-port operator-parameter RAM between sequencer reads and host register writes.

Parameters:
- CLK_DIV_COUNT, 256, clk cycles per sample period; must exceed NUM_BANKS*NUM_OPERATORS_PER_BANK*OP_CYCLES.
- OP_CYCLES, 4, clk cycles spent on each operator slot; must be ≥2.

Ports:
- clk  in  1  system clock.
- ic_n  in  1  asynchronous, active-low reset (initial clear).
- sample_clk_en  out  1  one-cycle pulse once per sample period.
- slot_valid  out  1  high on every cycle a slot is being sequenced.
- bank_num  out  1  current bank (0..1).
- op_num  out  5  current operator within the bank (0..17).
- slot_phase  out  $clog2(OP_CYCLES)  cycle index within the current slot.
- ram_rd_en  out  1  parameter RAM read strobe for the current slot.
- frame_done  out  1  one-cycle pulse on the last cycle of the last slot.
- host_wr_req  in  1  host requests a parameter RAM write; held until granted.
- host_wr_gnt  out  1  write accepted this cycle.

Behaviour:
- Reset (ic_n low, asynchronous), all registers cleared:
  - divider count = 0, state = IDLE;
  - bank_num, op_num, slot_phase = 0;
  - sample_clk_en, slot_valid, ram_rd_en, frame_done = 0.
- Reset asserted mid-frame aborts the frame immediately. No partial completion, no frame_done.
- Divider:
  - div_cnt counts 0..CLK_DIV_COUNT-1 and wraps to 0.
  - sample_clk_en is registered, high during the cycle where div_cnt == CLK_DIV_COUNT-1.
  - First pulse appears CLK_DIV_COUNT cycles after ic_n deasserts.
- FSM states: IDLE, RUN.
  - IDLE→RUN on the edge where sample_clk_en is high. The first RUN cycle has bank 0, op 0, phase 0.
  - In RUN, slot_phase increments each cycle and wraps at OP_CYCLES-1.
  - On phase wrap, op_num increments. After 17 it wraps to 0 and bank_num increments.
  - On the cycle with bank 1, op 17, phase OP_CYCLES-1: frame_done = 1. Next state is IDLE, with indices returning to 0.
  - A RUN frame lasts exactly 36*OP_CYCLES cycles (144 at defaults).
- Output rules:
  - slot_valid = (state == RUN).
  - ram_rd_en = slot_valid && slot_phase == 0.
  - In IDLE, bank_num, op_num and slot_phase read 0.
- sample_clk_en arriving while in RUN is impossible under the parameter constraint. An assertion flags it; on occurrence the sequencer restarts at slot 0.
- Arbitration:
  - host_wr_gnt = host_wr_req && !ram_rd_en. This is combinational, same-cycle.
  - Sequencer reads always win. Grant and read are never high together.
  - The worst-case host wait is 1 cycle.
  - A request held across IDLE is granted immediately.
- All indices have fixed widths, wrap explicitly and never overflow.

Decomposition:
- Package opl3_pkg holds:
  - constants NUM_BANKS = 2, NUM_OPERATORS_PER_BANK = 18;
  - typedefs bank_num_t (logic), op_num_t (logic [4:0]);
  - enum sched_state_t {IDLE, RUN}.
- One natural sub-module: opl3_slot_counter. It is the phase/op/bank nested counter with enable, wrap and last-slot flag.
- The top level holds the divider, FSM and arbiter.

Test Plan:
- Release ic_n at cycle 0 (defaults) -> sample_clk_en first high at cycle 255; repeats every 256 cycles; exactly 1 cycle wide.
- Observe one frame -> slot_valid high 144 consecutive cycles starting the cycle after sample_clk_en. Indices step (0,0),(0,1)..(0,17),(1,0)..(1,17), each held 4 cycles. frame_done is high only on the 144th cycle.
- Hold host_wr_req continuously through a frame -> host_wr_gnt low exactly on the 36 ram_rd_en cycles, high on all others, never coincident with ram_rd_en.
- Pulse host_wr_req on a phase-0 cycle (bank 0, op 5) and hold -> grant one cycle later at phase 1.
- Drop ic_n at bank 1, op 3, phase 2 -> all outputs 0 asynchronously and no frame_done. After release, next sample_clk_en at 256 cycles and a full 144-cycle frame.
- Set OP_CYCLES=2, CLK_DIV_COUNT=73 -> frame length 72 cycles; the IDLE gap is 1 cycle; no RUN overlap assertion fires.

Source files
------------

// File: rtl/opl3_pkg.sv
// Shared constants and types for the OPL3 operator slot sequencer.
package opl3_pkg;

  localparam int unsigned NUM_BANKS              = 2;
  localparam int unsigned NUM_OPERATORS_PER_BANK = 18;

  typedef logic       bank_num_t;
  typedef logic [4:0] op_num_t;

  typedef enum logic {StIdle, StRun} sched_state_t;

  localparam op_num_t   LastOp   = op_num_t'(NUM_OPERATORS_PER_BANK - 1);
  localparam bank_num_t LastBank = bank_num_t'(NUM_BANKS - 1);

endpackage

// File: rtl/opl3_slot_counter.sv
// Nested phase/operator/bank counter; flags the final phase of the final slot.
module opl3_slot_counter
  import opl3_pkg::*;
#(
  parameter int unsigned OpCycles = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clr_i,
  input  logic                        en_i,
  output logic [$clog2(OpCycles)-1:0] phase_o,
  output logic [4:0]                  op_o,
  output logic                        bank_o,
  output logic                        last_o
);

  localparam int unsigned PhaseW = $clog2(OpCycles);
  localparam logic [PhaseW-1:0] LastPhase = PhaseW'(OpCycles - 1);

  logic [PhaseW-1:0] phase_d, phase_q;
  op_num_t           op_d, op_q;
  bank_num_t         bank_d, bank_q;

  always_comb begin
    phase_d = phase_q;
    op_d    = op_q;
    bank_d  = bank_q;
    if (clr_i) begin
      phase_d = '0;
      op_d    = '0;
      bank_d  = '0;
    end else if (en_i) begin
      if (phase_q == LastPhase) begin
        phase_d = '0;
        if (op_q == LastOp) begin
          op_d   = '0;
          bank_d = (bank_q == LastBank) ? 1'b0 : bank_q + 1'b1;
        end else begin
          op_d = op_q + 5'd1;
        end
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= '0;
      op_q    <= '0;
      bank_q  <= '0;
    end else begin
      phase_q <= phase_d;
      op_q    <= op_d;
      bank_q  <= bank_d;
    end
  end

  assign phase_o = phase_q;
  assign op_o    = op_q;
  assign bank_o  = bank_q;
  assign last_o  = (bank_q == LastBank) && (op_q == LastOp) && (phase_q == LastPhase);

endmodule

// File: rtl/opl3_slot_scheduler.sv
// Sample-rate divider, slot sequencing FSM and parameter-RAM write arbiter.
module opl3_slot_scheduler
  import opl3_pkg::*;
#(
  parameter int unsigned ClkDivCount = 256,
  parameter int unsigned OpCycles    = 4
) (
  input  logic                        clk_i,
  input  logic                        ic_ni,
  output logic                        sample_clk_en_o,
  output logic                        slot_valid_o,
  output logic                        bank_num_o,
  output logic [4:0]                  op_num_o,
  output logic [$clog2(OpCycles)-1:0] slot_phase_o,
  output logic                        ram_rd_en_o,
  output logic                        frame_done_o,
  input  logic                        host_wr_req_i,
  output logic                        host_wr_gnt_o
);

  localparam int unsigned DivW = $clog2(ClkDivCount);
  localparam logic [DivW-1:0] DivLast = DivW'(ClkDivCount - 1);

  logic [DivW-1:0] div_cnt_d, div_cnt_q;
  logic            sample_clk_en_d, sample_clk_en_q;
  sched_state_t    state_d, state_q;
  logic            cnt_en, cnt_clr, cnt_last;
  bank_num_t       bank;
  op_num_t         op;

  assign div_cnt_d       = (div_cnt_q == DivLast) ? '0 : div_cnt_q + 1'b1;
  // Registered so the strobe is high exactly while the count sits at its last value.
  assign sample_clk_en_d = (div_cnt_d == DivLast);

  always_comb begin
    state_d = state_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_clr = 1'b1;
        if (sample_clk_en_q) state_d = StRun;
      end
      StRun: begin
        // A new sample mid-frame restarts the walk from slot 0.
        if (sample_clk_en_q) begin
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
          if (cnt_last) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge ic_ni) begin
    if (!ic_ni) begin
      div_cnt_q       <= '0;
      sample_clk_en_q <= 1'b0;
      state_q         <= StIdle;
    end else begin
      div_cnt_q       <= div_cnt_d;
      sample_clk_en_q <= sample_clk_en_d;
      state_q         <= state_d;
    end
  end

  opl3_slot_counter #(
    .OpCycles(OpCycles)
  ) u_slot_counter (
    .clk_i  (clk_i),
    .rst_ni (ic_ni),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .phase_o(slot_phase_o),
    .op_o   (op),
    .bank_o (bank),
    .last_o (cnt_last)
  );

  assign sample_clk_en_o = sample_clk_en_q;
  assign slot_valid_o    = (state_q == StRun);
  assign bank_num_o      = bank;
  assign op_num_o        = op;
  assign ram_rd_en_o     = slot_valid_o && (slot_phase_o == '0);
  assign frame_done_o    = slot_valid_o && cnt_last;
  assign host_wr_gnt_o   = host_wr_req_i && !ram_rd_en_o;

  a_no_sample_in_run: assert property (
    @(posedge clk_i) disable iff (!ic_ni) !(sample_clk_en_q && state_q == StRun));

endmodule

// File: tb/tb_opl3_slot_scheduler.sv
// Scoreboard bench: default-parameter instance plus a 2-cycle/73-divider instance.
module tb_opl3_slot_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ic_n_a, ic_n_b, req_a, req_b;
  logic samp_a, valid_a, bank_a, rd_a, done_a, gnt_a;
  logic [4:0] op_a;
  logic [1:0] ph_a;
  logic samp_b, valid_b, bank_b, rd_b, done_b, gnt_b;
  logic [4:0] op_b;
  logic [0:0] ph_b;

  opl3_slot_scheduler dut_a (
    .clk_i(clk), .ic_ni(ic_n_a), .sample_clk_en_o(samp_a), .slot_valid_o(valid_a),
    .bank_num_o(bank_a), .op_num_o(op_a), .slot_phase_o(ph_a), .ram_rd_en_o(rd_a),
    .frame_done_o(done_a), .host_wr_req_i(req_a), .host_wr_gnt_o(gnt_a)
  );

  opl3_slot_scheduler #(.ClkDivCount(73), .OpCycles(2)) dut_b (
    .clk_i(clk), .ic_ni(ic_n_b), .sample_clk_en_o(samp_b), .slot_valid_o(valid_b),
    .bank_num_o(bank_b), .op_num_o(op_b), .slot_phase_o(ph_b), .ram_rd_en_o(rd_b),
    .frame_done_o(done_b), .host_wr_req_i(req_b), .host_wr_gnt_o(gnt_b)
  );

  typedef struct {
    int cyc; int bank; int op; int phase; int rd; int done; int gnt;
  } slot_exp_t;
  typedef struct { int start; int len; } frame_exp_t;

  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         base;
  int         q_samp[$];
  slot_exp_t  q_slot[$];
  frame_exp_t q_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit req_sched(input int r);
    return (r >= 200 && r <= 400) || (r >= 532 && r <= 700);
  endfunction

  task automatic push_frame(input int b, input int start, input int n, input bit seg1);
    slot_exp_t e;
    for (int i = 0; i < n; i++) begin
      e.cyc   = b + start + i;
      e.phase = i % 4;
      e.op    = (i / 4) % 18;
      e.bank  = i / 72;
      e.rd    = (e.phase == 0) ? 1 : 0;
      e.done  = (i == 143) ? 1 : 0;
      e.gnt   = (seg1 && req_sched(start + i) && e.rd == 0) ? 1 : 0;
      q_slot.push_back(e);
    end
  endtask

  // Monitor for the default instance.
  slot_exp_t m;
  always @(negedge clk) begin
    if (samp_a) begin
      if (q_samp.size() == 0) chk("samp_unexpected", int'(samp_a), 0);
      else chk("samp_cycle", cyc, q_samp.pop_front());
    end
    if (valid_a) begin
      if (q_slot.size() == 0) begin
        chk("slot_unexpected", int'(valid_a), 0);
      end else begin
        m = q_slot.pop_front();
        chk("slot_cycle", cyc, m.cyc);
        chk("bank", int'(bank_a), m.bank);
        chk("op", int'(op_a), m.op);
        chk("phase", int'(ph_a), m.phase);
        chk("ram_rd_en", int'(rd_a), m.rd);
        chk("frame_done", int'(done_a), m.done);
        chk("gnt", int'(gnt_a), m.gnt);
      end
    end else begin
      chk("idle_idx", int'({bank_a, op_a, ph_a}), 0);
      chk("idle_rd_done", int'({rd_a, done_a}), 0);
      chk("idle_gnt", int'(gnt_a), int'(req_a));
    end
    if (rd_a && gnt_a) chk("gnt_with_rd", int'(gnt_a), 0);
  end

  // Monitor for the short-frame instance: frame start, length and done position.
  logic prev_vb = 1'b0;
  int   run_start, run_len, done_pos;
  frame_exp_t fb;
  always @(negedge clk) begin
    if (valid_b && !prev_vb) begin
      run_start = cyc;
      run_len   = 0;
      done_pos  = -1;
      if (q_b.size() != 0) begin
        chk("b_start_idx", int'({bank_b, op_b, ph_b}), 0);
        chk("b_start_rd_gnt", int'({rd_b, gnt_b}), 2);
      end
    end
    if (valid_b) begin
      if (done_b) done_pos = run_len;
      run_len++;
    end else if (done_b) begin
      chk("b_done_idle", int'(done_b), 0);
    end
    if (!valid_b && prev_vb && q_b.size() != 0) begin
      fb = q_b.pop_front();
      chk("b_frame_start", run_start, fb.start);
      chk("b_frame_len", run_len, fb.len);
      chk("b_done_pos", done_pos, fb.len - 1);
    end
    prev_vb = valid_b;
  end

  initial begin
    ic_n_a = 1'b0;
    ic_n_b = 1'b0;
    req_a  = 1'b0;
    req_b  = 1'b1;
    repeat (3) @(negedge clk);
    ic_n_a = 1'b1;
    ic_n_b = 1'b1;
    base   = cyc;
    q_samp.push_back(base + 255);
    q_samp.push_back(base + 511);
    q_samp.push_back(base + 767);
    push_frame(base, 256, 144, 1'b1);
    push_frame(base, 512, 144, 1'b1);
    push_frame(base, 768, 86, 1'b1);   // aborted at bank 1, op 3, phase 2
    for (int k = 0; k < 10; k++) q_b.push_back('{start: base + 73 + 73 * k, len: 72});

    for (int r = 1; r <= 854; r++) begin
      @(posedge clk);
      #2;
      req_a = req_sched(r);
    end
    ic_n_a = 1'b0;
    #1;
    chk("async_clear", int'({valid_a, samp_a, rd_a, done_a, bank_a, op_a, ph_a}), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    ic_n_a = 1'b1;
    base   = cyc;
    q_samp.push_back(base + 255);
    push_frame(base, 256, 144, 1'b0);
    repeat (420) @(posedge clk);
    @(negedge clk);

    chk("samp_queue_left", q_samp.size(), 0);
    chk("slot_queue_left", q_slot.size(), 0);
    chk("b_queue_left", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
